kernel_map_node_pipe: RTL

- Parametrised leaf map node for TyBEC-generated pipelines.
- Applies one elementwise binary op (add/sub/min/max, selected per item) across LANES parallel lanes of DATAW-bit signed data.
- The result passes through a PIPE_DEPTH-stage register pipeline with valid/ready handshake, external stall and an accepted-item counter.
- Sits between stream ports and downstream map/reduce nodes.

---
 rtl/kernel_map_node_pipe_pkg.sv | 19 +
 rtl/kernel_map_node_pipe_if.sv | 49 ++++
 rtl/kernel_map_node_pipe_lane_alu.sv | 82 ++++++++
 rtl/kernel_map_node_pipe.sv | 93 +++++++++
 4 files changed

// File: rtl/kernel_map_node_pipe_pkg.sv
// ============================================================================
// Module  : tybec_mapnode_pkg
// Brief   : Opcode encodings shared by the kernel map node and its lane ALUs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tybec_mapnode_pkg;

  localparam int OPW = 2;

  localparam logic [OPW-1:0] OP_ADD = 2'd0;
  localparam logic [OPW-1:0] OP_SUB = 2'd1;
  localparam logic [OPW-1:0] OP_MIN = 2'd2;
  localparam logic [OPW-1:0] OP_MAX = 2'd3;

endpackage

`default_nettype wire

// File: rtl/kernel_map_node_pipe_if.sv
// ============================================================================
// Module  : kernel_map_node_pipe_if
// Brief   : Stream-in / stream-out bundle of the map node; sat_flag exists
//           only when MAPNODE_SAT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface kernel_map_node_pipe_if
  import tybec_mapnode_pkg::*;
#(
  parameter int DATAW = 32,
  parameter int LANES = 4,
  parameter int CNTW  = 32
);

  logic                   stall;
  logic                   in_valid;
  logic                   in_ready;
  logic [OPW-1:0]         in_op;
  logic [LANES*DATAW-1:0] in1;
  logic [LANES*DATAW-1:0] in2;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*DATAW-1:0] out1;
  logic [CNTW-1:0]        item_count;
`ifdef MAPNODE_SAT_EN
  logic                   sat_flag;
`endif

  modport master (
    output stall, in_valid, in_op, in1, in2, out_ready,
    input  in_ready, out_valid, out1, item_count
`ifdef MAPNODE_SAT_EN
    , input sat_flag
`endif
  );

  modport slave (
    input  stall, in_valid, in_op, in1, in2, out_ready,
    output in_ready, out_valid, out1, item_count
`ifdef MAPNODE_SAT_EN
    , output sat_flag
`endif
  );

endinterface

`default_nettype wire

// File: rtl/kernel_map_node_pipe_lane_alu.sv
// ============================================================================
// Module  : mapnode_lane_alu
// Brief   : Combinational signed add/sub/min/max for one lane; saturating
//           add/sub with a sat indication when MAPNODE_SAT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mapnode_lane_alu
  import tybec_mapnode_pkg::*;
#(
  parameter int DATAW = 32
) (
  input  logic [DATAW-1:0] a,
  input  logic [DATAW-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic [DATAW-1:0] y
`ifdef MAPNODE_SAT_EN
  , output logic           sat
`endif
);

  logic w_b_lt_a;
  logic w_b_gt_a;

  assign w_b_lt_a = $signed(b) < $signed(a);
  assign w_b_gt_a = $signed(b) > $signed(a);

`ifdef MAPNODE_SAT_EN
  localparam logic [DATAW-1:0] C_MAX = {1'b0, {(DATAW-1){1'b1}}};
  localparam logic [DATAW-1:0] C_MIN = {1'b1, {(DATAW-1){1'b0}}};

  // One guard bit: overflow shows as the two top bits disagreeing.
  logic [DATAW:0] w_sum;
  logic [DATAW:0] w_diff;
  logic           w_sum_ovf;
  logic           w_diff_ovf;

  assign w_sum      = {a[DATAW-1], a} + {b[DATAW-1], b};
  assign w_diff     = {a[DATAW-1], a} - {b[DATAW-1], b};
  assign w_sum_ovf  = w_sum[DATAW] ^ w_sum[DATAW-1];
  assign w_diff_ovf = w_diff[DATAW] ^ w_diff[DATAW-1];

  always_comb begin
    y   = a;
    sat = 1'b0;
    case (op)
      OP_ADD: begin
        sat = w_sum_ovf;
        y   = w_sum_ovf ? (w_sum[DATAW] ? C_MIN : C_MAX) : w_sum[DATAW-1:0];
      end
      OP_SUB: begin
        sat = w_diff_ovf;
        y   = w_diff_ovf ? (w_diff[DATAW] ? C_MIN : C_MAX) : w_diff[DATAW-1:0];
      end
      OP_MIN:  y = w_b_lt_a ? b : a;
      OP_MAX:  y = w_b_gt_a ? b : a;
      default: y = a;
    endcase
  end
`else
  logic [DATAW-1:0] w_sum;
  logic [DATAW-1:0] w_diff;

  assign w_sum  = a + b;
  assign w_diff = a - b;

  always_comb begin
    y = a;
    case (op)
      OP_ADD:  y = w_sum;
      OP_SUB:  y = w_diff;
      OP_MIN:  y = w_b_lt_a ? b : a;
      OP_MAX:  y = w_b_gt_a ? b : a;
      default: y = a;
    endcase
  end
`endif

endmodule

`default_nettype wire

// File: rtl/kernel_map_node_pipe.sv
// ============================================================================
// Module  : kernel_map_node_pipe
// Brief   : LANES-wide elementwise map node feeding a PIPE_DEPTH-stage
//           valid/ready pipeline with stall and accepted-item counter.
//           Optional saturation and sticky sat_flag: MAPNODE_SAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module kernel_map_node_pipe
  import tybec_mapnode_pkg::*;
#(
  parameter int DATAW      = 32,
  parameter int LANES      = 4,
  parameter int PIPE_DEPTH = 2,
  parameter int CNTW       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  kernel_map_node_pipe_if.slave bus
);

  localparam int BUSW = LANES * DATAW;

  logic                  w_advance;
  logic                  w_accept;
  logic [BUSW-1:0]       w_result;
  logic [BUSW-1:0]       r_data [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] r_valid;
  logic [CNTW-1:0]       r_count;
`ifdef MAPNODE_SAT_EN
  logic [LANES-1:0]      w_sat;
  logic                  r_sat;
`endif

  // Whole pipe moves as one; the output slot frees when drained or empty.
  assign w_advance = !bus.stall && (bus.out_ready || !r_valid[PIPE_DEPTH-1]);
  assign w_accept  = bus.in_valid && w_advance;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mapnode_lane_alu #(
      .DATAW (DATAW)
    ) u_alu (
      .a   (bus.in1[i*DATAW +: DATAW]),
      .b   (bus.in2[i*DATAW +: DATAW]),
      .op  (bus.in_op),
      .y   (w_result[i*DATAW +: DATAW])
`ifdef MAPNODE_SAT_EN
      , .sat (w_sat[i])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
      end
      r_count <= '0;
    end else if (w_advance) begin
      r_valid[0] <= bus.in_valid;
      r_data[0]  <= w_result;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_data[k]  <= r_data[k-1];
      end
      if (bus.in_valid) begin
        r_count <= r_count + CNTW'(1);
      end
    end
  end

`ifdef MAPNODE_SAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (w_accept && (|w_sat)) begin
      r_sat <= 1'b1;
    end
  end

  assign bus.sat_flag = r_sat;
`endif

  assign bus.in_ready   = w_advance;
  assign bus.out_valid  = r_valid[PIPE_DEPTH-1];
  assign bus.out1       = r_data[PIPE_DEPTH-1];
  assign bus.item_count = r_count;

endmodule

`default_nettype wire
